mem_addr_unit: RTL and testbench
================================

Name: mem_addr_unit

Overview:
- Registered, parametrised successor to the combinational memory-address mux of the multicycle CPU.
- Selects the memory address from PC, ALU result, register A or register B.
- Contains an exception-vector sequencer. On an exception it saves EPC, drives the cause-specific vector address and waits for memory latency. It then captures the handler byte from memory and returns it as a zero-extended handler address.
- Sits between the control unit, the datapath registers and the memory port.

Parameters:
ADDR_W, 32, width of all address/data paths
MEM_LAT, 1, cycles from address presented to mem_rdata valid; legal range 1..15
VEC_DIV0, 253, vector address for divide-by-zero
VEC_OVF, 254, vector address for overflow
VEC_NOP, 255, vector address for invalid opcode

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
sel  in  2  source select: 00 PC, 01 ALU, 10 RegA, 11 RegB
addr_en  in  1  load addr_out from the selected source (IDLE only)
pc_in  in  ADDR_W  PC register output
alu_in  in  ADDR_W  ALU result
rega_in  in  ADDR_W  register A output
regb_in  in  ADDR_W  register B output
exc_req  in  1  exception request, sampled in IDLE only
exc_cause  in  2  01 div0, 10 overflow, 11 no-opcode; 00 invalid
mem_rdata  in  8  memory read byte
addr_out  out  ADDR_W  registered memory address
mem_rd  out  1  memory read strobe during vector fetch
exc_busy  out  1  sequencer active
exc_done  out  1  one-cycle pulse: handler_addr valid
handler_addr  out  ADDR_W  zero-extended handler byte
epc_out  out  ADDR_W  PC saved at exception accept

Behaviour:
- Reset (reset=0, asynchronous):
  - State is IDLE and the latency counter is 0.
  - addr_out, handler_addr and epc_out are 0.
  - mem_rd, exc_busy and exc_done are 0.
  - Reset asserted mid-fetch aborts immediately. No exc_done is emitted.
- States: IDLE, FETCH.
- IDLE:
  - If exc_req=1 and exc_cause≠00 at an edge:
    - epc_out <= pc_in.
    - addr_out <= zero-extended vector for the cause.
    - counter <= 1; exc_busy <= 1; mem_rd <= 1; go to FETCH.
  - Otherwise, if addr_en=1: addr_out <= source chosen by sel. Latency is 1 cycle (visible after the edge).
  - Otherwise: addr_out holds.
  - exc_req with exc_cause=00 is ignored and treated as no request; addr_en is still honoured that cycle.
  - exc_req and addr_en in the same cycle: the exception wins and addr_en is dropped.
- FETCH:
  - addr_out holds the vector, and sel/addr_en/exc_req are ignored.
  - At each edge where counter < MEM_LAT: counter increments.
  - At the edge where counter = MEM_LAT:
    - handler_addr <= {zeros, mem_rdata}.
    - exc_done <= 1.
    - exc_busy <= 0; mem_rd <= 0; counter <= 0.
    - Return to IDLE.
- exc_done is high for exactly one cycle and cleared at the next edge. handler_addr and epc_out hold until the next accepted exception or reset.
- Total latency: exc_req sampled at edge E0; exc_done high in the cycle after edge E0+MEM_LAT.
- A new exception is only accepted in IDLE, so the earliest is in the cycle exc_done is high. A new exc_req in that cycle is accepted normally.
- Widths:
  - Vectors are truncated/zero-extended to ADDR_W.
  - mem_rdata is zero-extended into handler_addr.
  - No arithmetic wrap is involved.

Test Plan:
1. Reset, then sel=01 with alu_in=0x0000_0040 and addr_en=1 -> addr_out=0x40 one edge later. Then addr_en=0 with alu_in changed -> addr_out holds 0x40.
2. MEM_LAT=1: pc_in=0x0000_0100, exc_req=1, exc_cause=10 -> next cycle addr_out=254, mem_rd=1, exc_busy=1, epc_out=0x100. With mem_rdata=0x7C, the next edge gives exc_done=1 for one cycle, handler_addr=0x7C, exc_busy=0.
3. MEM_LAT=3, cause=01 -> addr_out=253 and mem_rd held for 3 cycles. exc_done asserts 3 edges after accept. addr_en and exc_req pulses during FETCH have no effect.
4. In IDLE, exc_req=1/cause=11 with addr_en=1/sel=00 in the same cycle -> addr_out=255, not pc_in. exc_req with cause=00 plus addr_en/sel=10 -> addr_out=rega_in and no FETCH.
5. Drop reset low during FETCH -> all outputs 0 immediately (asynchronously). After release: state IDLE, no exc_done.
6. Back-to-back: a second exc_req (cause=01) in the exc_done cycle -> accepted, new epc_out captured, sequence repeats correctly.

Source files
------------

// File: rtl/mem_addr_unit.sv
// Registered memory-address selector with an exception-vector sequencer.
// It saves EPC, fetches the handler byte at the cause vector, and returns it zero-extended.
module mem_addr_unit #(
  parameter int ADDR_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int VEC_DIV0 = 253,
  parameter int VEC_OVF  = 254,
  parameter int VEC_NOP  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        sel,
  input  logic              addr_en,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] alu_in,
  input  logic [ADDR_W-1:0] rega_in,
  input  logic [ADDR_W-1:0] regb_in,
  input  logic              exc_req,
  input  logic [1:0]        exc_cause,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] addr_out,
  output logic              mem_rd,
  output logic              exc_busy,
  output logic              exc_done,
  output logic [ADDR_W-1:0] handler_addr,
  output logic [ADDR_W-1:0] epc_out
);

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  localparam logic [3:0]        LAT       = 4'(MEM_LAT);
  localparam logic [ADDR_W-1:0] VEC_DIV0_A = ADDR_W'(VEC_DIV0);
  localparam logic [ADDR_W-1:0] VEC_OVF_A  = ADDR_W'(VEC_OVF);
  localparam logic [ADDR_W-1:0] VEC_NOP_A  = ADDR_W'(VEC_NOP);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt, handler_nxt, epc_nxt;
  logic [ADDR_W-1:0] vec_addr, src_addr;
  logic              mem_rd_nxt, busy_nxt, done_nxt;
  logic              exc_take;

  // A cause of 00 is not a real exception, so it must not start a fetch.
  assign exc_take = exc_req && (exc_cause != 2'b00);

  always_comb begin
    case (exc_cause)
      2'b01:   vec_addr = VEC_DIV0_A;
      2'b10:   vec_addr = VEC_OVF_A;
      default: vec_addr = VEC_NOP_A;
    endcase
  end

  always_comb begin
    case (sel)
      2'b00:   src_addr = pc_in;
      2'b01:   src_addr = alu_in;
      2'b10:   src_addr = rega_in;
      default: src_addr = regb_in;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      addr_out     <= '0;
      handler_addr <= '0;
      epc_out      <= '0;
      mem_rd       <= 1'b0;
      exc_busy     <= 1'b0;
      exc_done     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      addr_out     <= addr_nxt;
      handler_addr <= handler_nxt;
      epc_out      <= epc_nxt;
      mem_rd       <= mem_rd_nxt;
      exc_busy     <= busy_nxt;
      exc_done     <= done_nxt;
    end
  end

  // exc_done defaults low so it can only ever be a single-cycle pulse.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    addr_nxt    = addr_out;
    handler_nxt = handler_addr;
    epc_nxt     = epc_out;
    mem_rd_nxt  = mem_rd;
    busy_nxt    = exc_busy;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (exc_take) begin
          epc_nxt    = pc_in;
          addr_nxt   = vec_addr;
          cnt_nxt    = 4'd1;
          busy_nxt   = 1'b1;
          mem_rd_nxt = 1'b1;
          state_nxt  = FETCH;
        end else if (addr_en) begin
          addr_nxt = src_addr;
        end
      end
      FETCH: begin
        if (cnt == LAT) begin
          handler_nxt = ADDR_W'(mem_rdata);
          done_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          mem_rd_nxt  = 1'b0;
          cnt_nxt     = 4'd0;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_addr_unit.sv
// Directed bench for mem_addr_unit: one instance with MEM_LAT=1 and one with MEM_LAT=3
// share the same stimulus, and each check targets whichever instance the step exercises.
module tb_mem_addr_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sel;
  logic        addr_en;
  logic [31:0] pc_in, alu_in, rega_in, regb_in;
  logic        exc_req;
  logic [1:0]  exc_cause;
  logic [7:0]  mem_rdata;

  logic [31:0] addr1, hnd1, epc1, addr3, hnd3, epc3;
  logic        rd1, busy1, done1, rd3, busy3, done3;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_addr_unit #(.ADDR_W(32), .MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset), .sel(sel), .addr_en(addr_en),
    .pc_in(pc_in), .alu_in(alu_in), .rega_in(rega_in), .regb_in(regb_in),
    .exc_req(exc_req), .exc_cause(exc_cause), .mem_rdata(mem_rdata),
    .addr_out(addr1), .mem_rd(rd1), .exc_busy(busy1), .exc_done(done1),
    .handler_addr(hnd1), .epc_out(epc1)
  );

  mem_addr_unit #(.ADDR_W(32), .MEM_LAT(3)) u3 (
    .clk(clk), .reset(reset), .sel(sel), .addr_en(addr_en),
    .pc_in(pc_in), .alu_in(alu_in), .rega_in(rega_in), .regb_in(regb_in),
    .exc_req(exc_req), .exc_cause(exc_cause), .mem_rdata(mem_rdata),
    .addr_out(addr3), .mem_rd(rd3), .exc_busy(busy3), .exc_done(done3),
    .handler_addr(hnd3), .epc_out(epc3)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it before anything is sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exc_req = 1'b0;
    exc_cause = 2'b00;
    addr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; sel = 2'b00; addr_en = 1'b0;
    pc_in = '0; alu_in = '0; rega_in = '0; regb_in = '0;
    exc_req = 1'b0; exc_cause = 2'b00; mem_rdata = 8'h00;
    step(); step();
    check_output("rst_addr1", addr1, 32'h0);
    check_output("rst_rd1", rd1, 1'b0);
    check_output("rst_busy1", busy1, 1'b0);
    check_output("rst_done1", done1, 1'b0);
    check_output("rst_hnd1", hnd1, 32'h0);
    check_output("rst_epc1", epc1, 32'h0);
    check_output("rst_addr3", addr3, 32'h0);
    check_output("rst_busy3", busy3, 1'b0);
    reset = 1'b1;

    // Plain address loads and hold.
    sel = 2'b01; alu_in = 32'h40; addr_en = 1'b1;
    step();
    check_output("load_alu", addr1, 32'h40);
    addr_en = 1'b0; alu_in = 32'h99;
    step();
    check_output("hold_alu", addr1, 32'h40);
    sel = 2'b11; regb_in = 32'hCAFE_0001; addr_en = 1'b1;
    step();
    check_output("load_regb", addr1, 32'hCAFE_0001);
    addr_en = 1'b0;

    // Single-cycle latency fetch, overflow cause.
    pc_in = 32'h100; exc_req = 1'b1; exc_cause = 2'b10;
    step();
    check_output("ovf_addr", addr1, 32'd254);
    check_output("ovf_rd", rd1, 1'b1);
    check_output("ovf_busy", busy1, 1'b1);
    check_output("ovf_epc", epc1, 32'h100);
    check_output("ovf_done_early", done1, 1'b0);
    idle_inputs(); mem_rdata = 8'h7C;
    step();
    check_output("ovf_done", done1, 1'b1);
    check_output("ovf_hnd", hnd1, 32'h7C);
    check_output("ovf_busy_clr", busy1, 1'b0);
    check_output("ovf_rd_clr", rd1, 1'b0);
    check_output("l3_still_busy", busy3, 1'b1);
    step();
    check_output("ovf_done_pulse", done1, 1'b0);
    check_output("ovf_hnd_hold", hnd1, 32'h7C);
    step();
    check_output("l3_done", done3, 1'b1);
    check_output("l3_hnd", hnd3, 32'h7C);
    step();

    // Three-cycle latency fetch, divide-by-zero, with ignored requests mid-fetch.
    pc_in = 32'h200; exc_req = 1'b1; exc_cause = 2'b01;
    step();
    check_output("div0_addr", addr3, 32'd253);
    check_output("div0_rd", rd3, 1'b1);
    check_output("div0_epc", epc3, 32'h200);
    exc_cause = 2'b11; addr_en = 1'b1; sel = 2'b00; pc_in = 32'h300; mem_rdata = 8'h11;
    step();
    check_output("div0_addr_c1", addr3, 32'd253);
    check_output("div0_rd_c1", rd3, 1'b1);
    check_output("div0_done_c1", done3, 1'b0);
    step();
    check_output("div0_addr_c2", addr3, 32'd253);
    check_output("div0_done_c2", done3, 1'b0);
    check_output("div0_epc_c2", epc3, 32'h200);
    idle_inputs(); mem_rdata = 8'h5A;
    step();
    check_output("div0_done", done3, 1'b1);
    check_output("div0_hnd", hnd3, 32'h5A);
    check_output("div0_addr_end", addr3, 32'd253);
    check_output("div0_busy_clr", busy3, 1'b0);
    step();
    check_output("div0_done_pulse", done3, 1'b0);
    step(); step(); step();

    // Exception beats addr_en; cause 00 is ignored but addr_en still loads.
    exc_req = 1'b1; exc_cause = 2'b11; addr_en = 1'b1; sel = 2'b00; pc_in = 32'h400;
    step();
    check_output("nop_wins", addr1, 32'd255);
    check_output("nop_busy", busy1, 1'b1);
    idle_inputs();
    step(); step(); step(); step();
    exc_req = 1'b1; exc_cause = 2'b00; addr_en = 1'b1; sel = 2'b10; rega_in = 32'h1234;
    step();
    check_output("c00_rega1", addr1, 32'h1234);
    check_output("c00_busy1", busy1, 1'b0);
    check_output("c00_rd1", rd1, 1'b0);
    check_output("c00_rega3", addr3, 32'h1234);
    idle_inputs();

    // Asynchronous reset in the middle of a long fetch.
    exc_req = 1'b1; exc_cause = 2'b10; pc_in = 32'h500;
    step();
    check_output("ar_busy_pre", busy3, 1'b1);
    idle_inputs();
    step();
    #2 reset = 1'b0;
    #1;
    check_output("ar_addr3", addr3, 32'h0);
    check_output("ar_busy3", busy3, 1'b0);
    check_output("ar_rd3", rd3, 1'b0);
    check_output("ar_epc3", epc3, 32'h0);
    check_output("ar_hnd3", hnd3, 32'h0);
    check_output("ar_addr1", addr1, 32'h0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_output("ar_no_done", done3, 1'b0);
    end
    check_output("ar_idle_busy", busy3, 1'b0);

    // Back-to-back exceptions with a new request in the exc_done cycle.
    exc_req = 1'b1; exc_cause = 2'b10; pc_in = 32'h600; mem_rdata = 8'h21;
    step();
    check_output("b2b_epc_a", epc1, 32'h600);
    idle_inputs();
    step();
    check_output("b2b_done_a", done1, 1'b1);
    check_output("b2b_hnd_a", hnd1, 32'h21);
    exc_req = 1'b1; exc_cause = 2'b01; pc_in = 32'h700; mem_rdata = 8'h33;
    step();
    check_output("b2b_done_clr", done1, 1'b0);
    check_output("b2b_busy_b", busy1, 1'b1);
    check_output("b2b_addr_b", addr1, 32'd253);
    check_output("b2b_epc_b", epc1, 32'h700);
    check_output("b2b_hnd_hold", hnd1, 32'h21);
    idle_inputs();
    step();
    check_output("b2b_done_b", done1, 1'b1);
    check_output("b2b_hnd_b", hnd1, 32'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
